// File: rtl/param_shift_reg_if.sv
// Bundle of the data, control and status signals of param_shift_reg.
// The master modport drives control/data; the slave modport is the register itself.
interface param_shift_reg_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic             a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    logic             so;
    logic [CW-1:0]    fill_cnt;
    logic             full;
    logic             zero;
    logic             match;
    logic [7:0]       match_cnt;

    modport master (
        output en, mode, a, d,
        input  r, so, fill_cnt, full, zero, match, match_cnt
    );

    modport slave (
        input  en, mode, a, d,
        output r, so, fill_cnt, full, zero, match, match_cnt
    );
endinterface

// File: rtl/param_shift_reg.sv
// WIDTH-bit mode-selected shift/rotate/load register with fill counter and zero flag.
// Optional pattern detector (match/match_cnt) is built only when PATTERN_DETECT_EN is defined.
module param_shift_reg #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(4'b1011)
) (
    input  logic               clk,
    input  logic               rst_n,
    param_shift_reg_if.slave   bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    logic [WIDTH-1:0] r_q, r_d;
    logic             so_q, so_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    fill_inc_s;
    logic             shift_s;

    assign fill_inc_s = (fill_q == FULL_CNT) ? fill_q : fill_q + CW'(1);

    // Next-state decode of register contents, serial-out and fill counter
    always_comb begin
        r_d     = r_q;
        so_d    = so_q;
        fill_d  = fill_q;
        shift_s = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_SHL: begin
                    r_d     = {r_q[WIDTH-2:0], bus.a};
                    so_d    = r_q[WIDTH-1];
                    fill_d  = fill_inc_s;
                    shift_s = 1'b1;
                end
                MODE_SHR: begin
                    r_d     = {bus.a, r_q[WIDTH-1:1]};
                    so_d    = r_q[0];
                    fill_d  = fill_inc_s;
                    shift_s = 1'b1;
                end
                MODE_ROL: begin
                    r_d  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    so_d = r_q[WIDTH-1];
                end
                MODE_ROR: begin
                    r_d  = {r_q[0], r_q[WIDTH-1:1]};
                    so_d = r_q[0];
                end
                MODE_LOAD: begin
                    r_d    = bus.d;
                    so_d   = 1'b0;
                    fill_d = FULL_CNT;
                end
                MODE_CLEAR: begin
                    r_d    = '0;
                    so_d   = 1'b0;
                    fill_d = '0;
                end
                MODE_HOLD: begin
                    r_d = r_q;
                end
                default: begin
                    r_d = r_q;
                end
            endcase
        end else begin
            r_d = r_q;
        end
    end

    // Main state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            so_q   <= 1'b0;
            fill_q <= '0;
        end else begin
            r_q    <= r_d;
            so_q   <= so_d;
            fill_q <= fill_d;
        end
    end

    assign bus.r        = r_q;
    assign bus.so       = so_q;
    assign bus.fill_cnt = fill_q;
    assign bus.full     = (fill_q == FULL_CNT);
    assign bus.zero     = (r_q == '0);

`ifdef PATTERN_DETECT_EN
    logic       match_q, match_d;
    logic [7:0] match_cnt_q, match_cnt_d;

    // Match qualifies on the post-edge state, so the pulse lines up with the new r
    always_comb begin
        match_d     = shift_s && (r_d == PATTERN) && (fill_d == FULL_CNT);
        match_cnt_d = match_cnt_q;
        if (bus.en && (bus.mode == MODE_CLEAR)) begin
            match_cnt_d = 8'd0;
        end else if (match_d && (match_cnt_q != 8'd255)) begin
            match_cnt_d = match_cnt_q + 8'd1;
        end else begin
            match_cnt_d = match_cnt_q;
        end
    end

    // Detector registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q     <= 1'b0;
            match_cnt_q <= 8'd0;
        end else begin
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = match_cnt_q;
`else
    logic unused_s;
    assign unused_s      = shift_s ^ (|PATTERN);
    assign bus.match     = 1'b0;
    assign bus.match_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_param_shift_reg.sv
// Directed test of param_shift_reg at WIDTH=4, PATTERN=4'b1011.
module tb_param_shift_reg;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    param_shift_reg_if #(.WIDTH(4)) bus ();

    param_shift_reg #(.WIDTH(4), .PATTERN(4'b1011)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic ai, input logic [3:0] di);
        bus.en   = e;
        bus.mode = m;
        bus.a    = ai;
        bus.d    = di;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] er, input logic eso,
                               input logic [2:0] efill);
        check_eq({tag, ".r"}, 32'(bus.r), 32'(er));
        check_eq({tag, ".so"}, 32'(bus.so), 32'(eso));
        check_eq({tag, ".fill"}, 32'(bus.fill_cnt), 32'(efill));
        check_eq({tag, ".full"}, 32'(bus.full), 32'(efill == 3'd4));
        check_eq({tag, ".zero"}, 32'(bus.zero), 32'(er == 4'd0));
    endtask

    task automatic check_match(input string tag, input logic em, input logic [7:0] ecnt);
`ifdef PATTERN_DETECT_EN
        check_eq({tag, ".match"}, 32'(bus.match), 32'(em));
        check_eq({tag, ".mcnt"}, 32'(bus.match_cnt), 32'(ecnt));
`else
        check_eq({tag, ".match"}, 32'(bus.match), 32'(1'b0 & em));
        check_eq({tag, ".mcnt"}, 32'(bus.match_cnt), 32'(8'd0 & ecnt));
`endif
    endtask

    logic [3:0] shl_a;
    logic [3:0] shl_r [4];
    logic [3:0] ror_r [4];
    logic       ror_so[4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        shl_a    = 4'b1101;
        shl_r    = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        ror_r    = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
        ror_so   = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.mode = 3'b000;
        bus.a    = 1'b0;
        bus.d    = 4'b0000;

        // Reset state
        #12;
        check_state("reset", 4'b0000, 1'b0, 3'd0);
        check_match("reset", 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Shift left a=1,0,1,1 into the pattern
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b001, shl_a[i], 4'b0000);
            check_state($sformatf("shl%0d", i), shl_r[i], 1'b0, 3'(i + 1));
            check_match($sformatf("shl%0d", i), (i == 3), (i == 3) ? 8'd1 : 8'd0);
        end
        drive(1'b1, 3'b000, 1'b0, 4'b0000);
        check_state("hold", 4'b1011, 1'b0, 3'd4);
        check_match("hold", 1'b0, 8'd1);

        // Load then rotate right four times
        drive(1'b1, 3'b101, 1'b0, 4'b1001);
        check_state("load", 4'b1001, 1'b0, 3'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b100, 1'b0, 4'b0000);
            check_state($sformatf("ror%0d", i), ror_r[i], ror_so[i], 3'd4);
            check_match($sformatf("ror%0d", i), 1'b0, 8'd1);
        end

        // Asynchronous reset in the middle of a cycle
        drive(1'b1, 3'b101, 1'b0, 4'b1010);
        check_eq("pre_rst.r", 32'(bus.r), 32'h0000_000a);
        bus.mode = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 4'b0000, 1'b0, 3'd0);
        check_match("async_rst", 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Shift right from 1000, then hold with en low
        drive(1'b1, 3'b101, 1'b0, 4'b1000);
        drive(1'b1, 3'b010, 1'b0, 4'b0000);
        check_state("shr0", 4'b0100, 1'b0, 3'd4);
        drive(1'b1, 3'b010, 1'b0, 4'b0000);
        check_state("shr1", 4'b0010, 1'b0, 3'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b010, 1'b1, 4'b0000);
            check_state($sformatf("en0_%0d", i), 4'b0010, 1'b0, 3'd4);
        end

        // Back-to-back direction change, rotate left, reserved mode
        drive(1'b1, 3'b110, 1'b0, 4'b0000);
        check_state("clr", 4'b0000, 1'b0, 3'd0);
        drive(1'b1, 3'b001, 1'b1, 4'b0000);
        check_state("dir_l", 4'b0001, 1'b0, 3'd1);
        drive(1'b1, 3'b010, 1'b1, 4'b0000);
        check_state("dir_r", 4'b1000, 1'b1, 3'd2);
        drive(1'b1, 3'b011, 1'b0, 4'b0000);
        check_state("rol", 4'b0001, 1'b1, 3'd2);
        drive(1'b1, 3'b111, 1'b0, 4'b1111);
        check_state("rsvd", 4'b0001, 1'b1, 3'd2);

        // Pattern reached by shift vs. by direct load
        drive(1'b1, 3'b101, 1'b0, 4'b0101);
        check_match("ld0101", 1'b0, 8'd0);
        drive(1'b1, 3'b001, 1'b1, 4'b0000);
        check_state("pat_shl", 4'b1011, 1'b0, 3'd4);
        check_match("pat_shl", 1'b1, 8'd1);
        drive(1'b1, 3'b101, 1'b0, 4'b1011);
        check_state("pat_ld", 4'b1011, 1'b0, 3'd4);
        check_match("pat_ld", 1'b0, 8'd1);

        // Clear, then six shift-left edges to saturate the fill counter
        drive(1'b1, 3'b110, 1'b0, 4'b0000);
        check_state("clr2", 4'b0000, 1'b0, 3'd0);
        check_match("clr2", 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'b001, 1'b1, 4'b0000);
            check_state($sformatf("sat%0d", i), (i >= 3) ? 4'b1111 : 4'((1 << (i + 1)) - 1),
                        (i >= 4), (i >= 3) ? 3'd4 : 3'(i + 1));
        end
        drive(1'b1, 3'b110, 1'b0, 4'b0000);
        check_state("clr3", 4'b0000, 1'b0, 3'd0);
        check_match("clr3", 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
